// File: rtl/axi_arbiter.sv
// Two-master AXI arbiter in front of a single SRAM slave: IFU (m0, read-only) and
// LSU (m1, read/write) share one read channel; writes come from m1 only.
module axi_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        aclk,
    input  logic        aresetn,
    // m0: IFU read-only master
    input  logic [31:0] m0_araddr,
    input  logic        m0_arvalid,
    output logic        m0_arready,
    output logic [31:0] m0_rdata,
    output logic [1:0]  m0_rresp,
    output logic        m0_rvalid,
    input  logic        m0_rready,
    // m1: LSU read/write master
    input  logic [31:0] m1_araddr,
    input  logic        m1_arvalid,
    output logic        m1_arready,
    output logic [31:0] m1_rdata,
    output logic [1:0]  m1_rresp,
    output logic        m1_rvalid,
    input  logic        m1_rready,
    input  logic [31:0] m1_awaddr,
    input  logic        m1_awvalid,
    output logic        m1_awready,
    input  logic [31:0] m1_wdata,
    input  logic [7:0]  m1_wstrb,
    input  logic        m1_wvalid,
    output logic        m1_wready,
    output logic        m1_bvalid,
    output logic [1:0]  m1_bresp,
    input  logic        m1_bready,
    // downstream SRAM slave
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready,
    output logic [31:0] s_awaddr,
    output logic        s_awvalid,
    input  logic        s_awready,
    output logic [31:0] s_wdata,
    output logic [7:0]  s_wstrb,
    output logic        s_wvalid,
    input  logic        s_wready,
    input  logic        s_bvalid,
    input  logic [1:0]  s_bresp,
    output logic        s_bready
);

    localparam logic [1:0] R_IDLE   = 2'd0;
    localparam logic [1:0] R_ADDR   = 2'd1;
    localparam logic [1:0] R_DATA   = 2'd2;

    localparam logic [1:0] W_IDLE   = 2'd0;
    localparam logic [1:0] W_ACTIVE = 2'd1;
    localparam logic [1:0] W_RESP   = 2'd2;

    logic [1:0] r_state;
    logic [1:0] w_state;
    logic       owner;       // 0 = m0, 1 = m1
    logic       last_grant;  // owner of the last completed read
    logic       aw_done;
    logic       w_done;
    logic       pick;

    logic       r_addr_hs;
    logic       r_data_hs;
    logic       aw_hs;
    logic       w_hs;
    logic       b_hs;

    // On a tie the master that did not win last time gets the grant, unless m1 is fixed-priority.
    always_comb begin
        if (m0_arvalid && m1_arvalid)
            pick = PRIO_FIXED ? 1'b1 : ~last_grant;
        else
            pick = m1_arvalid;
    end

    assign r_addr_hs = (r_state == R_ADDR) && s_arvalid && s_arready;
    assign r_data_hs = (r_state == R_DATA) && s_rvalid && s_rready;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign b_hs      = (w_state == W_RESP) && s_bvalid && s_bready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state    <= R_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (m0_arvalid || m1_arvalid) begin
                        owner   <= pick;
                        r_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (r_addr_hs)
                        r_state <= R_DATA;
                end
                R_DATA: begin
                    if (r_data_hs) begin
                        last_grant <= owner;
                        r_state    <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    if (m1_awvalid || m1_wvalid)
                        w_state <= W_ACTIVE;
                end
                W_ACTIVE: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) && (w_done | w_hs))
                        w_state <= W_RESP;
                end
                W_RESP: begin
                    if (b_hs)
                        w_state <= W_IDLE;
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    // Read-side muxing; everything is held at 0 while aresetn is low.
    always_comb begin
        s_araddr   = 32'd0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rdata   = 32'd0;
        m0_rresp   = 2'd0;
        m0_rvalid  = 1'b0;
        m1_rdata   = 32'd0;
        m1_rresp   = 2'd0;
        m1_rvalid  = 1'b0;
        if (aresetn) begin
            if (r_state == R_ADDR) begin
                if (owner) begin
                    s_araddr   = m1_araddr;
                    s_arvalid  = m1_arvalid;
                    m1_arready = s_arready;
                end else begin
                    s_araddr   = m0_araddr;
                    s_arvalid  = m0_arvalid;
                    m0_arready = s_arready;
                end
            end else if (r_state == R_DATA) begin
                if (owner) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                    s_rready  = m1_rready;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                    s_rready  = m0_rready;
                end
            end
        end
    end

    // Write-side pass-through, masked per channel once its handshake has happened.
    always_comb begin
        s_awaddr   = 32'd0;
        s_awvalid  = 1'b0;
        s_wdata    = 32'd0;
        s_wstrb    = 8'd0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'd0;
        if (aresetn) begin
            if (w_state == W_ACTIVE) begin
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid && !aw_done;
                m1_awready = s_awready && !aw_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid && !w_done;
                m1_wready  = s_wready && !w_done;
            end else if (w_state == W_RESP) begin
                m1_bvalid = s_bvalid;
                m1_bresp  = s_bresp;
                s_bready  = m1_bready;
            end
        end
    end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: round-robin instance plus a fixed-priority instance
// sharing the same stimulus.
module tb_axi_arbiter;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata;
    logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
    logic        m1_awvalid, m1_wvalid, m1_bready;
    logic [7:0]  m1_wstrb;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [1:0]  s_rresp, s_bresp;

    // round-robin instance outputs
    logic        m0_arready, m0_rvalid, m1_arready, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
    logic        m1_awready, m1_wready, m1_bvalid;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [7:0]  s_wstrb;

    // fixed-priority instance outputs
    logic        m0_arready_f, m0_rvalid_f, m1_arready_f, m1_rvalid_f;
    logic [31:0] m0_rdata_f, m1_rdata_f;
    logic [1:0]  m0_rresp_f, m1_rresp_f, m1_bresp_f;
    logic        m1_awready_f, m1_wready_f, m1_bvalid_f;
    logic [31:0] s_araddr_f, s_awaddr_f, s_wdata_f;
    logic        s_arvalid_f, s_rready_f, s_awvalid_f, s_wvalid_f, s_bready_f;
    logic [7:0]  s_wstrb_f;

    int n_vec = 0;
    int n_err = 0;

    always #5 aclk = ~aclk;

    axi_arbiter #(.PRIO_FIXED(1'b0)) u_rr (
        .aclk(aclk), .aresetn(aresetn),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready)
    );

    axi_arbiter #(.PRIO_FIXED(1'b1)) u_fix (
        .aclk(aclk), .aresetn(aresetn),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready_f),
        .m0_rdata(m0_rdata_f), .m0_rresp(m0_rresp_f), .m0_rvalid(m0_rvalid_f), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready_f),
        .m1_rdata(m1_rdata_f), .m1_rresp(m1_rresp_f), .m1_rvalid(m1_rvalid_f), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready_f),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready_f),
        .m1_bvalid(m1_bvalid_f), .m1_bresp(m1_bresp_f), .m1_bready(m1_bready),
        .s_araddr(s_araddr_f), .s_arvalid(s_arvalid_f), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready_f),
        .s_awaddr(s_awaddr_f), .s_awvalid(s_awvalid_f), .s_awready(s_awready),
        .s_wdata(s_wdata_f), .s_wstrb(s_wstrb_f), .s_wvalid(s_wvalid_f), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready_f)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_araddr = 0; m0_arvalid = 0; m0_rready = 1;
        m1_araddr = 0; m1_arvalid = 0; m1_rready = 1;
        m1_awaddr = 0; m1_awvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wvalid = 0; m1_bready = 1;
        s_arready = 1; s_rdata = 0; s_rresp = 0; s_rvalid = 0;
        s_awready = 1; s_wready = 1; s_bvalid = 0; s_bresp = 0;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        clear_inputs();
        tick();
        tick();
        aresetn = 1'b1;
    endtask

    // One read on the round-robin instance starting in R_IDLE with arvalid(s) already driven.
    task automatic read_txn(input int own, input logic [31:0] exp_addr, input logic [31:0] rd);
        settle();
        check_val("rd_bubble_arvalid", 32'(s_arvalid), 0);
        tick();
        check_val("rd_s_arvalid", 32'(s_arvalid), 1);
        check_val("rd_s_araddr", s_araddr, exp_addr);
        check_val("rd_m0_arready", 32'(m0_arready), (own == 0) ? 1 : 0);
        check_val("rd_m1_arready", 32'(m1_arready), (own == 1) ? 1 : 0);
        tick();
        if (own == 0) m0_arvalid = 0; else m1_arvalid = 0;
        s_rvalid = 1; s_rdata = rd;
        settle();
        check_val("rd_m0_rvalid", 32'(m0_rvalid), (own == 0) ? 1 : 0);
        check_val("rd_m1_rvalid", 32'(m1_rvalid), (own == 1) ? 1 : 0);
        check_val("rd_owner_rdata", (own == 0) ? m0_rdata : m1_rdata, rd);
        check_val("rd_other_rdata", (own == 0) ? m1_rdata : m0_rdata, 0);
        tick();
        s_rvalid = 0; s_rdata = 0;
    endtask

    initial begin
        aresetn = 1'b0;
        clear_inputs();
        m0_arvalid = 1; m1_awvalid = 1; s_rvalid = 1; s_bvalid = 1;
        tick();
        settle();
        check_val("rst_s_arvalid", 32'(s_arvalid), 0);
        check_val("rst_m0_arready", 32'(m0_arready), 0);
        check_val("rst_m0_rvalid", 32'(m0_rvalid), 0);
        check_val("rst_s_awvalid", 32'(s_awvalid), 0);
        check_val("rst_m1_bvalid", 32'(m1_bvalid), 0);
        check_val("rst_s_rready", 32'(s_rready), 0);
        do_reset();

        // single m0 read
        m0_arvalid = 1; m0_araddr = 32'h8000_0000;
        read_txn(0, 32'h8000_0000, 32'h1234_5678);
        settle();
        check_val("rd_done_m0_rvalid", 32'(m0_rvalid), 0);

        // round-robin ties alternate, m1 first out of reset
        do_reset();
        m0_arvalid = 1; m0_araddr = 32'h0000_0100;
        m1_arvalid = 1; m1_araddr = 32'h0000_0200;
        read_txn(1, 32'h0000_0200, 32'hA1A1_0001);
        read_txn(0, 32'h0000_0100, 32'hA1A1_0002);
        m0_arvalid = 1; m1_arvalid = 1;
        read_txn(1, 32'h0000_0200, 32'hA1A1_0003);
        m1_arvalid = 1;
        read_txn(0, 32'h0000_0100, 32'hA1A1_0004);
        read_txn(1, 32'h0000_0200, 32'hA1A1_0005);

        // fixed priority: m1 wins every time while both keep requesting
        do_reset();
        m0_arvalid = 1; m0_araddr = 32'h0000_0300;
        m1_arvalid = 1; m1_araddr = 32'h0000_0400;
        for (int t = 0; t < 3; t++) begin
            settle();
            check_val("fix_idle_m0_arready", 32'(m0_arready_f), 0);
            tick();
            check_val("fix_s_araddr", s_araddr_f, 32'h0000_0400);
            check_val("fix_m1_arready", 32'(m1_arready_f), 1);
            check_val("fix_m0_arready", 32'(m0_arready_f), 0);
            tick();
            s_rvalid = 1; s_rdata = 32'h5A5A_0000 + 32'(t);
            settle();
            check_val("fix_m1_rvalid", 32'(m1_rvalid_f), 1);
            check_val("fix_m0_rvalid", 32'(m0_rvalid_f), 0);
            check_val("fix_data_m0_arready", 32'(m0_arready_f), 0);
            tick();
            s_rvalid = 0;
        end

        // m1 write: AW in cycle 0, W in cycle 3
        do_reset();
        m1_awvalid = 1; m1_awaddr = 32'h0000_0040;
        settle();
        check_val("wr_idle_s_awvalid", 32'(s_awvalid), 0);
        tick();
        check_val("wr_s_awvalid", 32'(s_awvalid), 1);
        check_val("wr_s_awaddr", s_awaddr, 32'h0000_0040);
        check_val("wr_m1_awready", 32'(m1_awready), 1);
        check_val("wr_s_wvalid_early", 32'(s_wvalid), 0);
        tick();
        check_val("wr_aw_masked", 32'(s_awvalid), 0);
        check_val("wr_awready_masked", 32'(m1_awready), 0);
        tick();
        m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 8'h0F;
        settle();
        check_val("wr_s_wvalid", 32'(s_wvalid), 1);
        check_val("wr_s_wdata", s_wdata, 32'hDEAD_BEEF);
        check_val("wr_s_wstrb", 32'(s_wstrb), 32'h0F);
        check_val("wr_m1_wready", 32'(m1_wready), 1);
        check_val("wr_aw_still_masked", 32'(s_awvalid), 0);
        tick();
        m1_awvalid = 0; m1_wvalid = 0;
        settle();
        check_val("wr_resp_no_bvalid", 32'(m1_bvalid), 0);
        check_val("wr_resp_s_bready", 32'(s_bready), 1);
        check_val("wr_resp_s_wvalid", 32'(s_wvalid), 0);
        tick();
        s_bvalid = 1; s_bresp = 2'd0;
        settle();
        check_val("wr_m1_bvalid", 32'(m1_bvalid), 1);
        check_val("wr_m1_bresp", 32'(m1_bresp), 0);
        tick();
        s_bvalid = 0;
        settle();
        check_val("wr_done_bvalid", 32'(m1_bvalid), 0);

        // same-cycle AW and W
        m1_awvalid = 1; m1_wvalid = 1; m1_awaddr = 32'h0000_0080; m1_wdata = 32'h0BAD_F00D;
        tick();
        check_val("wr2_s_awvalid", 32'(s_awvalid), 1);
        check_val("wr2_s_wvalid", 32'(s_wvalid), 1);
        tick();
        m1_awvalid = 0; m1_wvalid = 0; s_bvalid = 1; s_bresp = 2'd2;
        settle();
        check_val("wr2_m1_bvalid", 32'(m1_bvalid), 1);
        check_val("wr2_m1_bresp", 32'(m1_bresp), 2);
        tick();
        s_bvalid = 0; s_bresp = 0;

        // m0 holds rready low for 5 cycles in R_DATA
        do_reset();
        m0_arvalid = 1; m0_araddr = 32'h0000_0500; m0_rready = 0;
        tick();
        tick();
        m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'hCAFE_0001;
        for (int c = 0; c < 5; c++) begin
            settle();
            check_val("stall_s_rready", 32'(s_rready), 0);
            check_val("stall_m0_rvalid", 32'(m0_rvalid), 1);
            check_val("stall_m0_rdata", m0_rdata, 32'hCAFE_0001);
            tick();
        end
        m0_rready = 1;
        settle();
        check_val("stall_release_rready", 32'(s_rready), 1);
        tick();
        check_val("stall_done_rvalid", 32'(m0_rvalid), 0);
        s_rvalid = 0;

        // reset asserted mid-read and mid-write
        do_reset();
        m0_arvalid = 1; m0_araddr = 32'h0000_0600; m1_awvalid = 1; s_awready = 0;
        tick();
        tick();
        m0_arvalid = 0; s_rvalid = 1; s_rdata = 32'h7777_0000;
        settle();
        check_val("mid_m0_rvalid", 32'(m0_rvalid), 1);
        check_val("mid_s_awvalid", 32'(s_awvalid), 1);
        aresetn = 0;
        settle();
        check_val("mid_rst_m0_rvalid", 32'(m0_rvalid), 0);
        check_val("mid_rst_s_awvalid", 32'(s_awvalid), 0);
        tick();
        aresetn = 1; m1_awvalid = 0; s_awready = 1;
        settle();
        check_val("post_rst_m0_rvalid", 32'(m0_rvalid), 0);
        check_val("post_rst_s_rready", 32'(s_rready), 0);
        check_val("post_rst_s_awvalid", 32'(s_awvalid), 0);
        s_rvalid = 0; s_rdata = 0;
        m0_arvalid = 1; m0_araddr = 32'h0000_0700;
        read_txn(0, 32'h0000_0700, 32'h0FED_CBA9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
